qpix_event_capture: RTL and testbench

- 16-channel event timestamp capture block for the QPix readout FPGA; sits between the ASIC LVDS event outputs and the register file.
- Each rising edge on a channel's event line is timestamped from a free-running counter and pushed into a per-channel FIFO.
- Software pops each FIFO one word at a time via register-driven read strobes.
- Capture is enabled either by a manual trigger level or by an internal reset/window sampling sequencer, which also drives the ASIC reset line.

---
 rtl/qpix_capture_pkg.sv | 31 +++
 rtl/event_fifo.sv | 62 ++++++
 rtl/qpix_event_capture.sv | 118 +++++++++++
 tb/tb_qpix_event_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpix_capture_pkg.sv
// Shared constants, sequencer state encoding and event word layout for the
// QPix event capture block.
package qpix_capture_pkg;

  localparam int N_CH       = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int TS_W       = 31;
  localparam int DATA_W     = 32;

  localparam int EV_DT_BIT = 31;
  localparam int EV_TS_MSB = 30;
  localparam int EV_TS_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_GAP,
    ST_WAIT,
    ST_OPEN,
    ST_DONE
  } seq_state_t;

  function automatic logic [DATA_W-1:0] pack_event(input logic dt, input logic [TS_W-1:0] ts);
    logic [DATA_W-1:0] w;
    w = '0;
    w[EV_DT_BIT] = dt;
    w[EV_TS_MSB:EV_TS_LSB] = ts;
    return w;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-clock per-channel event FIFO with registered read data, registered
// empty/full flags and a sticky overflow flag.
module event_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      if (push && !do_push) ovf <= 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qpix_event_capture.sv
// 16-channel event timestamp capture with per-channel FIFOs and a
// reset/window sampling sequencer that drives the ASIC reset line.
module qpix_event_capture
  import qpix_capture_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          olvds,
  input  logic                     delta_t,
  input  logic                     trigger,
  input  logic [N_CH-1:0]          fifo_rd,
  input  logic                     window_start,
  input  logic [15:0]              reset_width,
  input  logic [15:0]              cal_gap,
  input  logic [15:0]              window_wait,
  input  logic [31:0]              window_width,
  output logic [N_CH*DATA_W-1:0]   fifo_dout,
  output logic [N_CH-1:0]          fifo_empty,
  output logic [N_CH-1:0]          fifo_full,
  output logic [N_CH-1:0]          fifo_ovf,
  output logic                     rst_ext,
  output logic                     window_open,
  output logic                     capture_en
);

  // state | meaning
  // IDLE  | waiting for window_start   RESET | rst_ext asserted   GAP | settle
  // WAIT  | pre-window delay           OPEN  | capture enabled    DONE | wait for window_start low
  seq_state_t      state, state_nxt;
  logic [31:0]     tmr, len, tmr_load;
  logic [TS_W-1:0] ts;
  logic [N_CH-1:0] olvds_q, rd_q, push, pop;
  logic [DATA_W-1:0] ev_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts      <= '0;
      olvds_q <= '0;
      rd_q    <= '0;
    end else begin
      ts      <= ts + 1'b1;
      olvds_q <= olvds;
      rd_q    <= fifo_rd;
    end
  end

  assign ev_word = pack_event(delta_t, ts);
  assign push    = olvds & ~olvds_q & {N_CH{capture_en}};
  assign pop     = fifo_rd & ~rd_q & ~fifo_empty;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    event_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (ev_word),
      .dout  (fifo_dout[i*DATA_W +: DATA_W]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i]),
      .ovf   (fifo_ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) tmr <= tmr_load;
      else if (tmr != '0)     tmr <= tmr - 1'b1;
    end
  end

  // Terminal count is zero, so a length of N (or 0) gives max(N,1) cycles.
  always_comb begin
    len = '0;
    case (state_nxt)
      ST_RESET: len = {16'd0, reset_width};
      ST_GAP:   len = {16'd0, cal_gap};
      ST_WAIT:  len = {16'd0, window_wait};
      ST_OPEN:  len = window_width;
      default:  len = '0;
    endcase
    tmr_load = (len == '0) ? '0 : len - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (!window_start) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_RESET;
        ST_RESET: if (tmr == '0) state_nxt = ST_GAP;
        ST_GAP:   if (tmr == '0) state_nxt = ST_WAIT;
        ST_WAIT:  if (tmr == '0) state_nxt = ST_OPEN;
        ST_OPEN:  if (tmr == '0) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rst_ext     = 1'b0;
    window_open = 1'b0;
    case (state)
      ST_RESET: rst_ext     = 1'b1;
      ST_OPEN:  window_open = 1'b1;
      default:  ;
    endcase
  end

  assign capture_en = trigger | window_open;

endmodule

// File: tb/tb_qpix_event_capture.sv
// Self-checking bench for qpix_event_capture: vector table plus directed
// multi-cycle sequences against a small per-channel FIFO model.
module tb_qpix_event_capture;

  localparam int NC = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC-1:0]   olvds = '0;
  logic            delta_t = 1'b0;
  logic            trigger = 1'b0;
  logic [NC-1:0]   fifo_rd = '0;
  logic            window_start = 1'b0;
  logic [15:0]     reset_width = '0;
  logic [15:0]     cal_gap = '0;
  logic [15:0]     window_wait = '0;
  logic [31:0]     window_width = '0;
  logic [NC*32-1:0] fifo_dout;
  logic [NC-1:0]   fifo_empty, fifo_full, fifo_ovf;
  logic            rst_ext, window_open, capture_en;

  qpix_event_capture dut (
    .clk(clk), .rst_n(rst_n), .olvds(olvds), .delta_t(delta_t), .trigger(trigger),
    .fifo_rd(fifo_rd), .window_start(window_start), .reset_width(reset_width),
    .cal_gap(cal_gap), .window_wait(window_wait), .window_width(window_width),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_ovf(fifo_ovf), .rst_ext(rst_ext), .window_open(window_open),
    .capture_en(capture_en)
  );

  always #10 clk = ~clk;

  logic [30:0] tb_ts;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;
  end

  logic [31:0] mq [NC][16];
  int          mh [NC];
  int          mc [NC];
  bit          mo [NC];
  logic [31:0] mlast [NC];
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit trig;
    int ch;
    int n;
    bit e;
    bit f;
    bit o;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_push(input int ch, input logic [31:0] w);
    if (mc[ch] < 16) begin
      mq[ch][(mh[ch] + mc[ch]) % 16] = w;
      mc[ch]++;
    end else begin
      mo[ch] = 1'b1;
    end
  endtask

  task automatic model_pop(input int ch);
    if (mc[ch] > 0) begin
      mlast[ch] = mq[ch][mh[ch]];
      mh[ch] = (mh[ch] + 1) % 16;
      mc[ch]--;
    end
  endtask

  task automatic check_flags(input int ch);
    chk($sformatf("empty[%0d]", ch), fifo_empty[ch], mc[ch] == 0);
    chk($sformatf("full[%0d]", ch),  fifo_full[ch],  mc[ch] == 16);
    chk($sformatf("ovf[%0d]", ch),   fifo_ovf[ch],   mo[ch]);
  endtask

  task automatic pulse(input int ch);
    @(negedge clk);
    olvds[ch] = 1'b1;
    if (trigger) model_push(ch, {delta_t, tb_ts});
    @(negedge clk);
    olvds[ch] = 1'b0;
  endtask

  task automatic rd(input int ch, input string nm);
    @(negedge clk);
    fifo_rd[ch] = 1'b1;
    model_pop(ch);
    @(negedge clk);
    fifo_rd[ch] = 1'b0;
    chk($sformatf("%s[%0d]", nm, ch), fifo_dout[ch*32 +: 32], mlast[ch]);
    check_flags(ch);
  endtask

  initial begin
    int first_rst, n_rst, first_open, n_open, pc;

    vecs[0] = '{1'b0, 3, 1,  1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2, 15, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2, 1,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2, 1,  1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 2, 2,  1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 4, 1,  1'b0, 1'b0, 1'b0};
    for (int c = 0; c < NC; c++) begin
      mh[c] = 0; mc[c] = 0; mo[c] = 1'b0; mlast[c] = '0;
    end

    // reset then idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_empty", fifo_empty, 64'hFFFF);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", fifo_ovf, 0);
    chk("rst_dout_zero", fifo_dout == '0, 1);
    chk("rst_rst_ext", rst_ext, 0);
    chk("rst_window_open", window_open, 0);
    chk("rst_capture_en", capture_en, 0);

    // channel 0 trigger capture, 5th read on empty holds data
    trigger = 1'b1;
    delta_t = 1'b1;
    repeat (4) pulse(0);
    check_flags(0);
    for (int r = 0; r < 5; r++) rd(0, "ch0_read");

    // all channels staggered by one cycle
    delta_t = 1'b0;
    for (int c = 1; c < NC; c++) begin
      @(negedge clk);
      olvds = '0;
      olvds[c] = 1'b1;
      model_push(c, {delta_t, tb_ts});
    end
    @(negedge clk);
    olvds = '0;
    for (int c = 1; c < NC; c++) rd(c, "allch_read");

    // vector table: gating, fill, overflow
    for (int v = 0; v < 6; v++) begin
      trigger = vecs[v].trig;
      for (int p = 0; p < vecs[v].n; p++) pulse(vecs[v].ch);
      chk($sformatf("vec%0d_empty", v), fifo_empty[vecs[v].ch], vecs[v].e);
      chk($sformatf("vec%0d_full", v),  fifo_full[vecs[v].ch],  vecs[v].f);
      chk($sformatf("vec%0d_ovf", v),   fifo_ovf[vecs[v].ch],   vecs[v].o);
    end
    for (int r = 0; r < 16; r++) rd(2, "ovf_read");
    rd(4, "ch4_read");

    // push and pop together on a full FIFO
    trigger = 1'b1;
    repeat (16) pulse(2);
    check_flags(2);
    @(negedge clk);
    olvds[2] = 1'b1;
    fifo_rd[2] = 1'b1;
    model_pop(2);
    model_push(2, {delta_t, tb_ts});
    @(negedge clk);
    olvds[2] = 1'b0;
    fifo_rd[2] = 1'b0;
    chk("simul_dout", fifo_dout[2*32 +: 32], mlast[2]);
    check_flags(2);
    for (int r = 0; r < 16; r++) rd(2, "simul_drain");

    // held-high read pops once
    pulse(0);
    pulse(0);
    @(negedge clk);
    fifo_rd[0] = 1'b1;
    model_pop(0);
    repeat (4) @(negedge clk);
    chk("held_rd_dout", fifo_dout[31:0], mlast[0]);
    check_flags(0);
    fifo_rd[0] = 1'b0;
    rd(0, "held_rd_next");

    // window sequence timing and capture gating
    trigger = 1'b0;
    reset_width = 16'd250;
    cal_gap = 16'd5;
    window_wait = 16'd100;
    window_width = 32'd100;
    first_rst = -1; n_rst = 0; first_open = -1; n_open = 0;
    @(negedge clk);
    window_start = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rst_ext) begin
        if (first_rst < 0) first_rst = k;
        n_rst++;
      end
      if (window_open) begin
        if (first_open < 0) first_open = k;
        n_open++;
      end
      if (k == 300 || k == 400) chk($sformatf("capture_en_k%0d", k), capture_en, k == 400);
      olvds = '0;
      pc = -1;
      case (k)
        354: pc = 5;
        355: pc = 6;
        454: pc = 7;
        455: pc = 8;
        default: pc = -1;
      endcase
      if (pc >= 0) begin
        olvds[pc] = 1'b1;
        if (k >= 355 && k < 455) model_push(pc, {delta_t, tb_ts});
      end
    end
    @(negedge clk);
    olvds = '0;
    chk("win_rst_first", first_rst, 0);
    chk("win_rst_len", n_rst, 250);
    chk("win_open_first", first_open, 355);
    chk("win_open_len", n_open, 100);
    window_start = 1'b0;
    @(negedge clk);
    chk("win_idle_rst_ext", rst_ext, 0);
    chk("win_idle_open", window_open, 0);
    for (int c = 5; c <= 8; c++) check_flags(c);
    rd(6, "win_read");
    rd(7, "win_read");

    // minimum lengths, then drop window_start mid-OPEN
    reset_width = 16'd2;
    cal_gap = 16'd0;
    window_wait = 16'd0;
    window_width = 32'd50;
    first_open = -1;
    @(negedge clk);
    window_start = 1'b1;
    for (int k = 0; k < 40 && first_open < 0; k++) begin
      @(negedge clk);
      if (window_open) first_open = k;
    end
    chk("short_open_first", first_open, 4);
    repeat (3) @(negedge clk);
    chk("open_before_drop", window_open, 1);
    window_start = 1'b0;
    @(negedge clk);
    chk("open_after_drop", window_open, 0);
    chk("capture_after_drop", capture_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
